// File: rtl/char_buf_pkg.sv
// char_buf_pkg: shared definitions for the writable character buffer.
//   buf_state_t  fill/idle controller states
//   LF_CODE, CR_CODE, FILL_CODE  control and blank character codes
//   idx_w()      index width for a power-of-two dimension (min 1 bit)
package char_buf_pkg;

  typedef enum logic [1:0] {
    FILL_ALL,
    IDLE,
    FILL_LINE
  } buf_state_t;

  localparam logic [7:0] LF_CODE   = 8'h0A;
  localparam logic [7:0] CR_CODE   = 8'h0D;
  localparam logic [7:0] FILL_CODE = 8'h20;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/char_buf_ram.sv
// char_buf_ram: simple dual-port character RAM.
//   clk, rst   clock, async active-high reset (read register only)
//   we, waddr, wdata   write port
//   raddr, rdata       registered read port, read-first on address collision
module char_buf_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking update means a same-cycle write is seen only on the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/char_text_buf.sv
// char_text_buf: writable COLS x ROWS character buffer with cursor, CR/LF,
// line wrap, hardware scroll (rotating top row) and full-screen clear.
//   clk, rst        clock, async active-high reset (starts a full clear)
//   wr_valid/ready  host character handshake, wr_code the character
//   clr             pulse: clear screen and home the cursor
//   char_xy         display read address {row, col} in logical coordinates
//   char_code_out   registered character code of char_xy (1-cycle latency)
//   cur_col/cur_row cursor position, busy = clear/scroll fill running
module char_text_buf
  import char_buf_pkg::*;
#(
  parameter int unsigned       COLS   = 16,
  parameter int unsigned       ROWS   = 16,
  parameter int unsigned       CODE_W = 7,
  parameter logic [CODE_W-1:0] FILL   = CODE_W'(FILL_CODE),
  localparam int unsigned      CW     = idx_w(COLS),
  localparam int unsigned      RW     = idx_w(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              clr,
  input  logic [RW+CW-1:0]  char_xy,
  output logic [CODE_W-1:0] char_code_out,
  output logic [CW-1:0]     cur_col,
  output logic [RW-1:0]     cur_row,
  output logic              busy
);

  localparam int unsigned AW = RW + CW;

  buf_state_t        state;
  logic [AW-1:0]     fill_cnt;
  logic [RW-1:0]     top;
  logic              accept, is_lf, is_cr, at_last_col, row_adv;
  logic              we;
  logic [AW-1:0]     waddr, raddr;
  logic [CODE_W-1:0] wdata;
  logic [RW-1:0]     cur_phys_row, rd_phys_row, bot_phys_row;

  assign busy        = (state != IDLE);
  assign wr_ready    = (state == IDLE) && !clr;
  assign accept      = wr_valid && wr_ready;
  assign is_lf       = (wr_code == CODE_W'(LF_CODE));
  assign is_cr       = (wr_code == CODE_W'(CR_CODE));
  assign at_last_col = (cur_col == CW'(COLS - 1));
  assign row_adv     = accept && (is_lf || (!is_cr && at_last_col));

  // Logical rows map to physical rows rotated by top; top-1 is the new bottom line.
  assign cur_phys_row = cur_row + top;
  assign rd_phys_row  = char_xy[AW-1:CW] + top;
  assign bot_phys_row = top - RW'(1);
  assign raddr        = {rd_phys_row, char_xy[CW-1:0]};

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = FILL;
    case (state)
      FILL_ALL: begin
        we    = 1'b1;
        waddr = fill_cnt;
      end
      FILL_LINE: begin
        we    = 1'b1;
        waddr = {bot_phys_row, fill_cnt[CW-1:0]};
      end
      default: begin
        we    = accept && !is_lf && !is_cr;
        waddr = {cur_phys_row, cur_col};
        wdata = wr_code;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL_ALL;
      fill_cnt <= '0;
      top      <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
    end else begin
      case (state)
        FILL_ALL: begin
          // Counter wraps back to zero on the last cell, ready for the next fill.
          fill_cnt <= fill_cnt + AW'(1);
          if (fill_cnt == '1) begin
            state   <= IDLE;
            top     <= '0;
            cur_col <= '0;
            cur_row <= '0;
          end
        end
        FILL_LINE: begin
          if (fill_cnt == AW'(COLS - 1)) begin
            fill_cnt <= '0;
            state    <= IDLE;
          end else begin
            fill_cnt <= fill_cnt + AW'(1);
          end
        end
        IDLE: begin
          if (clr) begin
            state    <= FILL_ALL;
            fill_cnt <= '0;
          end else if (accept) begin
            if (is_lf || is_cr || at_last_col) cur_col <= '0;
            else                               cur_col <= cur_col + CW'(1);
            if (row_adv) begin
              if (cur_row != RW'(ROWS - 1)) begin
                cur_row <= cur_row + RW'(1);
              end else begin
                top      <= top + RW'(1);
                state    <= FILL_LINE;
                fill_cnt <= '0;
              end
            end
          end
        end
        default: state <= FILL_ALL;
      endcase
    end
  end

  char_buf_ram #(
    .AW(AW),
    .DW(CODE_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(char_code_out)
  );

endmodule
